// File: rtl/instr_dispatch_fsm.sv
// Instruction sequencer: fetches 16-bit words, dispatches them to the
// ALU control FSM via start/done, and reports run/halt/error status.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   run                   start execution from START_ADDR (IDLE/HALT only)
//   instr_addr, instr_rd  instruction memory address/read strobe
//   instr_data            instruction word (data valid the cycle after rd)
//   start, opCode, Ri, Rj request and operands to the ALU control FSM
//   done                  completion pulse from the ALU control FSM
//   busy, halted, error   status; error is a sticky done-timeout flag
//   instr_count           completed dispatched instructions, saturating
module instr_dispatch_fsm #(
    parameter int ADDR_W       = 8,
    parameter int START_ADDR   = 0,
    parameter int DONE_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_rd,
    input  logic [15:0]       instr_data,
    output logic              start,
    output logic [3:0]        opCode,
    output logic [5:0]        Ri,
    output logic [5:0]        Rj,
    input  logic              done,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [15:0]       instr_count
);

    localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    // Last WAIT_DONE cycle that may still accept done before timing out.
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(DONE_TIMEOUT - 1);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_DONE,
        S_ADVANCE,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [CNT_W-1:0]  to_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= START_PC;
            ir          <= '0;
            to_cnt      <= '0;
            instr_count <= '0;
            error       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (run)
                        state <= S_FETCH;
                end
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir <= instr_data;
                    if (instr_data[15:12] == OP_NOP)
                        state <= S_ADVANCE;
                    else if (instr_data[15:12] == OP_HALT)
                        state <= S_HALT;
                    else
                        state <= S_ISSUE;
                end
                S_ISSUE: begin
                    to_cnt <= '0;
                    state  <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // done takes priority over a coincident timeout
                    if (done) begin
                        state <= S_ADVANCE;
                    end else if (to_cnt == TO_LAST) begin
                        error <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_ADVANCE: begin
                    pc <= pc + 1'b1;
                    if (ir[15:12] != OP_NOP && instr_count != 16'hFFFF)
                        instr_count <= instr_count + 16'd1;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    if (run) begin
                        pc          <= START_PC;
                        error       <= 1'b0;
                        instr_count <= '0;
                        state       <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs: operands come straight from IR, so they only
    // change when DECODE loads a new word.
    assign instr_addr = pc;
    assign instr_rd   = (state == S_FETCH);
    assign start      = (state == S_ISSUE);
    assign opCode     = ir[15:12];
    assign Ri         = ir[11:6];
    assign Rj         = ir[5:0];
    assign halted     = (state == S_HALT);
    assign busy       = (state != S_IDLE) && (state != S_HALT);

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Scoreboard bench for instr_dispatch_fsm with a memory and ALU model.
// A program-walking reference model predicts every dispatch.
module tb_instr_dispatch_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (ADDR_W = 8) ----------------
    logic        reset, run, done;
    logic [7:0]  instr_addr;
    logic        instr_rd;
    logic [15:0] instr_data;
    logic        start;
    logic [3:0]  opCode;
    logic [5:0]  Ri, Rj;
    logic        busy, halted, error;
    logic [15:0] instr_count;

    instr_dispatch_fsm #(.ADDR_W(8), .START_ADDR(0), .DONE_TIMEOUT(15)) u_dut (
        .clk(clk), .reset(reset), .run(run),
        .instr_addr(instr_addr), .instr_rd(instr_rd), .instr_data(instr_data),
        .start(start), .opCode(opCode), .Ri(Ri), .Rj(Rj), .done(done),
        .busy(busy), .halted(halted), .error(error), .instr_count(instr_count)
    );

    logic [15:0] mem [256];
    logic [15:0] rdata = 16'h0;
    always @(posedge clk) if (instr_rd) rdata <= mem[instr_addr];
    assign instr_data = rdata;

    // ALU model: done in the 5th cycle after the start cycle
    int   dly = 0;
    logic alu_mute = 1'b0;
    logic idle_done = 1'b0;
    logic issue_done = 1'b0;
    logic inject = 1'b0;
    always @(posedge clk) begin
        if (start) dly <= 5;
        else if (dly > 0) dly <= dly - 1;
    end
    assign done = ((dly == 1) && !alu_mute) || idle_done || issue_done;

    // ---------------- wrap instance (ADDR_W = 2) ----------------
    logic        rst2, run2, done2;
    logic [1:0]  addr2;
    logic        rd2, start2, busy2, halted2, err2;
    logic [15:0] data2, cnt2;
    logic [3:0]  op2;
    logic [5:0]  ri2, rj2;

    instr_dispatch_fsm #(.ADDR_W(2), .START_ADDR(0), .DONE_TIMEOUT(15)) u_dut2 (
        .clk(clk), .reset(rst2), .run(run2),
        .instr_addr(addr2), .instr_rd(rd2), .instr_data(data2),
        .start(start2), .opCode(op2), .Ri(ri2), .Rj(rj2), .done(done2),
        .busy(busy2), .halted(halted2), .error(err2), .instr_count(cnt2)
    );

    logic [15:0] mem2 [4];
    logic [15:0] rdata2 = 16'h0;
    int          dly2 = 0;
    always @(posedge clk) if (rd2) rdata2 <= mem2[addr2];
    assign data2 = rdata2;
    always @(posedge clk) begin
        if (start2) dly2 <= 5;
        else if (dly2 > 0) dly2 <= dly2 - 1;
    end
    assign done2 = (dly2 == 1);

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    logic [15:0] exp_q [$];
    logic [15:0] mon_e;
    logic        in_flight = 1'b0;
    logic        prev_start = 1'b0;

    // Monitor: every start pops one expected dispatch; operands must
    // then hold until done (or the timeout halt).
    always @(negedge clk) begin
        if (reset) begin
            in_flight  = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (start) begin
                chk("start_single_cycle", 32'(prev_start), 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start actual=%0h required=none",
                             {opCode, Ri, Rj});
                    mon_e = {opCode, Ri, Rj};
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("dispatch_ops", 32'({opCode, Ri, Rj}), 32'(mon_e));
                end
                in_flight = 1'b1;
            end else if (in_flight) begin
                chk("ops_stable", 32'({opCode, Ri, Rj}), 32'(mon_e));
                if (done || halted) in_flight = 1'b0;
            end
            prev_start = start;
        end
    end

    // Inject a done pulse during ISSUE; it must be ignored.
    always @(negedge clk) begin
        if (inject && start && !reset) begin
            issue_done = 1'b1;
            @(posedge clk);
            #1 issue_done = 1'b0;
        end
    end

    // Reference model: walk the program as the spec describes it.
    task automatic model(output int hpc, output int cnt);
        int pc;
        logic [15:0] w;
        pc = 0;
        cnt = 0;
        for (int s = 0; s < 256; s++) begin
            w = mem[pc];
            if (w[15:12] == 4'hF) break;
            if (w[15:12] != 4'h0) begin
                exp_q.push_back(w);
                cnt++;
            end
            pc = (pc + 1) % 256;
        end
        hpc = pc;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_halted(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(halted), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n, nd, hpc, cnt, len;
        logic [3:0] op;
        logic ok;

        reset = 1'b1; run = 1'b0; rst2 = 1'b1; run2 = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_addr", 32'(instr_addr), 0);
        chk("rst_rd", 32'(instr_rd), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_ops", 32'({opCode, Ri, Rj}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_count", 32'(instr_count), 0);
        reset = 1'b0;
        rst2  = 1'b0;
        @(negedge clk);
        chk("idle_no_run", 32'(busy), 0);

        // ADDR_W=2 wrap
        mem2[0] = 16'h1041; mem2[1] = 16'h2082;
        mem2[2] = 16'h30C3; mem2[3] = 16'h4104;
        run2 = 1'b1;
        @(negedge clk);
        run2 = 1'b0;
        nd = 0; n = 0;
        while (nd < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (done2) nd++;
        end
        chk("wrap_done4", 32'(nd), 4);
        repeat (2) @(negedge clk);
        chk("wrap_addr", 32'(addr2), 0);
        chk("wrap_count4", 32'(cnt2), 4);
        n = 0;
        while (!done2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("wrap_count5", 32'(cnt2), 5);
        chk("wrap_addr1", 32'(addr2), 1);
        rst2 = 1'b1;

        // directed program with cycle timing
        mem[0] = 16'h7042; mem[1] = 16'h0000; mem[2] = 16'hF000;
        exp_q.push_back(16'h7042);
        run = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                run = 1'b0;
                chk("t_rd_n1", 32'(instr_rd), 1);
            end
            if (k == 2) chk("t_rd_n2", 32'(instr_rd), 0);
            if (k == 3) chk("t_start_n3", 32'(start), 1);
            if (k == 4) chk("t_start_n4", 32'(start), 0);
            if (k == 9) chk("t_pc_n9", 32'(instr_addr), 0);
            if (k == 10) chk("t_pc_n10", 32'(instr_addr), 1);
        end
        wait_halted("t_halted", 100);
        chk("t_addr", 32'(instr_addr), 2);
        chk("t_count", 32'(instr_count), 1);
        chk("t_error", 32'(error), 0);
        chk("t_queue_empty", 32'(exp_q.size()), 0);

        // random programs against the reference model
        for (int r = 0; r < 6; r++) begin
            clear_mem();
            len = $urandom_range(3, 14);
            for (int i = 0; i < len; i++) begin
                op = ($urandom_range(0, 3) == 0) ? 4'h0
                     : 4'($urandom_range(1, 14));
                mem[i] = {op, 12'($urandom)};
            end
            mem[len] = {4'hF, 12'($urandom)};
            model(hpc, cnt);
            pulse_run();
            wait_halted("r_halted", 400);
            chk("r_addr", 32'(instr_addr), 32'(hpc));
            chk("r_count", 32'(instr_count), 32'(cnt));
            chk("r_error", 32'(error), 0);
            chk("r_queue_empty", 32'(exp_q.size()), 0);
        end

        // done timeout
        clear_mem();
        mem[0] = 16'h1005; mem[1] = 16'hF000;
        alu_mute = 1'b1;
        exp_q.push_back(16'h1005);
        pulse_run();
        n = 0;
        while (!start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_start_seen", 32'(start), 1);
        n = 0;
        while (!halted && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), 16);
        chk("to_error", 32'(error), 1);
        chk("to_halted", 32'(halted), 1);
        chk("to_addr", 32'(instr_addr), 0);
        chk("to_count", 32'(instr_count), 0);
        alu_mute = 1'b0;
        exp_q.push_back(16'h1005);
        pulse_run();
        chk("to_err_clear", 32'(error), 0);
        chk("to_refetch_rd", 32'(instr_rd), 1);
        chk("to_refetch_addr", 32'(instr_addr), 0);
        wait_halted("to_rerun_halted", 100);
        chk("to_rerun_count", 32'(instr_count), 1);
        chk("to_rerun_addr", 32'(instr_addr), 1);

        // async reset during WAIT_DONE
        clear_mem();
        mem[0] = 16'h2041; mem[1] = 16'h3083; mem[2] = 16'hF000;
        exp_q.push_back(16'h2041);
        exp_q.push_back(16'h3083);
        pulse_run();
        n = 0;
        while (!(start && instr_addr == 8'd1) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ar_second_start", 32'(start), 1);
        repeat (2) @(negedge clk);
        chk("ar_pre_count", 32'(instr_count), 1);
        chk("ar_pre_busy", 32'(busy), 1);
        #1 reset = 1'b1;
        #1;
        chk("ar_start", 32'(start), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_ops", 32'({opCode, Ri, Rj}), 0);
        chk("ar_count", 32'(instr_count), 0);
        chk("ar_addr", 32'(instr_addr), 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (busy || halted || start) ok = 1'b0;
        end
        chk("ar_late_done_ignored", 32'(ok), 1);
        chk("ar_queue_empty", 32'(exp_q.size()), 0);

        // done in IDLE / ISSUE and run held while busy
        idle_done = 1'b1;
        @(negedge clk);
        idle_done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", 32'(busy), 0);
        chk("idle_done_addr", 32'(instr_addr), 0);
        clear_mem();
        mem[0] = 16'h4001; mem[1] = 16'h0000; mem[2] = 16'h5002;
        mem[3] = 16'h6003; mem[4] = 16'hF000;
        model(hpc, cnt);
        inject = 1'b1;
        run = 1'b1;
        repeat (20) @(negedge clk);
        run = 1'b0;
        wait_halted("rh_halted", 100);
        inject = 1'b0;
        chk("rh_addr", 32'(instr_addr), 32'(hpc));
        chk("rh_count", 32'(instr_count), 32'(cnt));
        chk("rh_error", 32'(error), 0);
        chk("rh_queue_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
